sha2_msg_schedule: RTL

Produces the per-round message word Wj that feeds the SHA-2 round datapath. It accepts the 16 words of one padded message block over a valid/ready stream and emits W0..W(R-1) in order on a second valid/ready stream. Words W0..W15 are the input words passed through; later words are expanded internally with a 16-entry circular buffer. A single parameter selects SHA-256 (32-bit, 64 rounds) or SHA-512 (64-bit, 80 rounds).

---
 rtl/sha2_msg_schedule.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sha2_msg_schedule.sv
// SHA-2 message schedule: streams W0..W(ROUNDS-1) for one 16-word block.
// W0..W15 pass straight through; later words are expanded from a 16-entry circular buffer.
module sha2_msg_schedule #(
    parameter int unsigned WORDSIZE = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORDSIZE-1:0] in_word,
    output logic                w_valid,
    input  logic                w_ready,
    output logic [WORDSIZE-1:0] w_out,
    output logic [6:0]          w_idx,
    output logic                w_last,
    output logic                busy
);

    localparam int unsigned ROUNDS = (WORDSIZE == 64) ? 80 : 64;
    localparam logic [6:0]  LastIdx = 7'(ROUNDS - 1);

    if (WORDSIZE != 32 && WORDSIZE != 64) begin : g_bad_wordsize
        $error("sha2_msg_schedule: WORDSIZE must be 32 or 64");
    end

    typedef enum logic [0:0] {StLoad, StExpand} state_e;

    state_e              state_q;
    logic [6:0]          j_q;
    logic [WORDSIZE-1:0] msg_q [16];
    logic                w_valid_q;
    logic [WORDSIZE-1:0] w_out_q;
    logic [6:0]          w_idx_q;
    logic                w_last_q;

    function automatic logic [WORDSIZE-1:0] rotr(input logic [WORDSIZE-1:0] x,
                                                 input int unsigned n);
        return (x >> n) | (x << (WORDSIZE - n));
    endfunction

    function automatic logic [WORDSIZE-1:0] sig0(input logic [WORDSIZE-1:0] x);
        if (WORDSIZE == 32) return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
        return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    endfunction

    function automatic logic [WORDSIZE-1:0] sig1(input logic [WORDSIZE-1:0] x);
        if (WORDSIZE == 32) return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
        return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    endfunction

    logic                adv;
    logic                in_fire;
    logic [3:0]          slot;
    logic [3:0]          idx_m2;
    logic [3:0]          idx_m7;
    logic [3:0]          idx_m15;
    logic [WORDSIZE-1:0] w_exp;

    assign adv      = !w_valid_q || w_ready;
    assign in_ready = !rst && (state_q == StLoad) && adv;
    assign in_fire  = in_valid && in_ready;

    // Buffer slot j mod 16 holds W(j-16) until it is overwritten with Wj.
    always_comb begin
        slot    = j_q[3:0];
        idx_m2  = slot - 4'd2;
        idx_m7  = slot - 4'd7;
        idx_m15 = slot + 4'd1;
        w_exp   = sig1(msg_q[idx_m2]) + msg_q[idx_m7] + sig0(msg_q[idx_m15]) + msg_q[slot];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StLoad;
            j_q       <= '0;
            w_valid_q <= 1'b0;
            w_out_q   <= '0;
            w_idx_q   <= '0;
            w_last_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                msg_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (in_fire) begin
                        msg_q[slot] <= in_word;
                        w_out_q     <= in_word;
                        w_idx_q     <= j_q;
                        w_valid_q   <= 1'b1;
                        w_last_q    <= 1'b0;
                        j_q         <= j_q + 7'd1;
                        if (j_q == 7'd15) begin
                            state_q <= StExpand;
                        end
                    end else if (adv) begin
                        w_valid_q <= 1'b0;
                        w_last_q  <= 1'b0;
                    end
                end
                StExpand: begin
                    if (adv) begin
                        msg_q[slot] <= w_exp;
                        w_out_q     <= w_exp;
                        w_idx_q     <= j_q;
                        w_valid_q   <= 1'b1;
                        if (j_q == LastIdx) begin
                            w_last_q <= 1'b1;
                            j_q      <= '0;
                            state_q  <= StLoad;
                        end else begin
                            w_last_q <= 1'b0;
                            j_q      <= j_q + 7'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign w_valid = w_valid_q;
    assign w_out   = w_out_q;
    assign w_idx   = w_idx_q;
    assign w_last  = w_last_q;
    assign busy    = (state_q == StExpand) || (j_q != 7'd0) || w_valid_q;

endmodule
